csr_access_ctrl: RTL and testbench
==================================

// Module: csr_access_ctrl
// PURPOSE
//  Sequences every CSR-class instruction (CSRRD/CSRWR/CSRXCHG) from the execute stage onto the
//  single CSR-file read/write port pair. One op in flight at a time, so CSR ops are strictly
//  in order. Returns the old CSR value for rd writeback. Sits between EX and the CSR register
//  file; the decoder supplies op, csr_addr, rd value and rj mask.
// PARAMETERS
//  CSR_AW   14  CSR address width
//  DW       32  data width
//  RD_LAT   1   CSR-file read latency in cycles, >=1
// PORTS
//  clk         in   1      clock; all logic is rising-edge
//  rst         in   1      reset, synchronous, active-high
//  flush       in   1      pipeline flush (exception/ertn/branch kill)
//  req_valid   in   1      CSR op request
//  req_ready   out  1      controller can accept
//  req_op      in   2      00 RD, 01 WR, 10 XCHG, 11 reserved
//  req_addr    in   CSR_AW CSR number (inst[23:10])
//  req_wdata   in   DW     rd register value (new data)
//  req_mask    in   DW     rj register value (XCHG write mask)
//  req_rd      in   5      writeback register
//  csr_re      out  1      CSR-file read strobe
//  csr_raddr   out  CSR_AW read address
//  csr_rdata   in   DW     read data, valid RD_LAT cycles after csr_re
//  csr_we      out  1      CSR-file write strobe
//  csr_waddr   out  CSR_AW write address
//  csr_wdata   out  DW     write data
//  resp_valid  out  1      old value ready for writeback
//  resp_ready  in   1      writeback accepts
//  resp_data   out  DW     old CSR value
//  resp_rd     out  5      writeback register
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  - FSM: IDLE -> READ -> WAIT -> (WRITE if op WR/XCHG) -> RESP -> IDLE.
//  - IDLE: req_ready = !flush. Handshake req_valid&&req_ready latches op/addr/wdata/mask/rd.
//  - READ: csr_re=1 for exactly one cycle, csr_raddr=latched addr.
//  - WAIT: down-counter loaded with RD_LAT-1; captures csr_rdata into old_q on count==0.
//  - WRITE: csr_we=1 one cycle, csr_waddr=addr. WR: wdata=req_wdata.
//    XCHG: wdata=(req_wdata & mask)|(old_q & ~mask). Mask all-0 writes old_q back unchanged.
//  - RESP: resp_valid=1, resp_data=old_q, resp_rd held stable until resp_ready; then IDLE.
//  - Reserved op 11: executes as RD, never writes.
//  - Latency: accept at T gives resp_valid at T+2+RD_LAT (RD), T+3+RD_LAT (WR/XCHG).
//  - Back-to-back: next req accepted earliest the cycle after the RESP handshake; no bypass.
//  - flush in any non-IDLE state: next state IDLE, csr_we forced 0 that cycle (no partial
//    write), pending resp dropped. flush in IDLE with req_valid: request not accepted.
//  - Reset: state=IDLE, counter=0, old_q=0, all strobes/valids 0, addr/data outputs 0.
//  - csr_re/csr_we never asserted in the same cycle; at most one write per accepted op.
// STRUCTURE
//  - CSR op encodings (CSR_OP_RD/WR/XCHG) and state encodings go in defines.vh next to the
//    ALU_CSR* codes; the decoder maps ALU_CSRRD/CSRWR/CSRXCHG onto req_op.
//  - Single flat module; XCHG merge is one expression, no sub-module.
// TESTING
//  1 CSRRD 0x0005 with rdata=0xDEAD_BEEF, RD_LAT=1 -> csr_re at T+1, resp_valid T+3,
//    resp_data 0xDEAD_BEEF, csr_we never high.
//  2 CSRWR addr 0x0006, wdata 0x1234_5678, old 0xA5A5_A5A5 -> one csr_we, wdata 0x1234_5678,
//    resp_data 0xA5A5_A5A5 at T+4.
//  3 CSRXCHG old 0xFFFF_0000, wdata 0x0F0F_0F0F, mask 0x00FF_FF00 -> csr_wdata 0xFF0F_0F00.
//  4 flush asserted in WRITE cycle -> csr_we=0, resp_valid never rises, busy=0 next cycle.
//  5 resp_ready low 5 cycles -> resp_valid/data/rd stable; req_ready=0 throughout; second
//    queued req accepted cycle after handshake.
//  6 RD_LAT=3, and rst pulse mid-WAIT -> capture at 3rd WAIT cycle; after rst all outputs 0, IDLE.

Source files
------------

// File: rtl/csr_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// csr_access_ctrl_pkg
//  Shared encodings for the CSR access controller: the CSR op codes driven by
//  the decoder onto req_op, the controller FSM states, and a small helper that
//  tells whether an op performs a CSR-file write.
// ----------------------------------------------------------------------------
package csr_access_ctrl_pkg;

    // CSR op encoding on req_op; the decoder maps ALU_CSRRD/CSRWR/CSRXCHG here
    typedef enum logic [1:0] {
        CSR_OP_RD   = 2'b00,
        CSR_OP_WR   = 2'b01,
        CSR_OP_XCHG = 2'b10,
        CSR_OP_RSVD = 2'b11
    } csr_op_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } csr_state_e;

    // Only WR and XCHG write the CSR file; the reserved code behaves as a read
    function automatic logic op_writes(input csr_op_e op);
        logic wr_s;
        case (op)
            CSR_OP_WR:   wr_s = 1'b1;
            CSR_OP_XCHG: wr_s = 1'b1;
            default:     wr_s = 1'b0;
        endcase
        return wr_s;
    endfunction

endpackage

// File: rtl/csr_access_ctrl.sv
// ----------------------------------------------------------------------------
// csr_access_ctrl
//  Sequences CSRRD / CSRWR / CSRXCHG from the execute stage onto the single
//  CSR-file read/write port pair, one op in flight at a time, and returns the
//  old CSR value for rd writeback.
//
//  Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               pipeline kill; aborts any op in flight
//   req_*               request handshake from EX (op, addr, new data, mask, rd)
//   csr_re/csr_raddr    CSR-file read strobe and address
//   csr_rdata           read data, valid RD_LAT cycles after csr_re
//   csr_we/waddr/wdata  CSR-file write strobe, address and data
//   resp_*              old-value writeback handshake (data, rd)
//   busy                controller is not idle
// ----------------------------------------------------------------------------
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int CSR_AW = 14,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [CSR_AW-1:0] req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW-1:0]     req_mask,
    input  logic [4:0]        req_rd,
    output logic              csr_re,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [DW-1:0]     csr_rdata,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [DW-1:0]     csr_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DW-1:0]     resp_data,
    output logic [4:0]        resp_rd,
    output logic              busy
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    csr_state_e        state_r;
    csr_op_e           op_r;
    logic [CSR_AW-1:0] addr_r;
    logic [DW-1:0]     wdata_r;
    logic [DW-1:0]     mask_r;
    logic [4:0]        rd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DW-1:0]     old_r;
    logic              csr_re_r;
    logic [CSR_AW-1:0] csr_raddr_r;
    logic              csr_we_r;
    logic [CSR_AW-1:0] csr_waddr_r;
    logic [DW-1:0]     csr_wdata_r;
    logic              resp_valid_r;
    logic [DW-1:0]     merge_s;

    // XCHG merge: masked bits from the new value, the rest from the old value.
    // csr_rdata is used directly because it is captured into old_r on the same
    // edge that the write data is registered.
    assign merge_s = (wdata_r & mask_r) | (csr_rdata & ~mask_r);

    // Controller FSM, operand latches and registered CSR-port/response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= CSR_OP_RD;
            addr_r       <= {CSR_AW{1'b0}};
            wdata_r      <= {DW{1'b0}};
            mask_r       <= {DW{1'b0}};
            rd_r         <= 5'd0;
            cnt_r        <= {CNT_W{1'b0}};
            old_r        <= {DW{1'b0}};
            csr_re_r     <= 1'b0;
            csr_raddr_r  <= {CSR_AW{1'b0}};
            csr_we_r     <= 1'b0;
            csr_waddr_r  <= {CSR_AW{1'b0}};
            csr_wdata_r  <= {DW{1'b0}};
            resp_valid_r <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless a state re-asserts them
            csr_re_r <= 1'b0;
            csr_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        op_r        <= csr_op_e'(req_op);
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        mask_r      <= req_mask;
                        rd_r        <= req_rd;
                        csr_re_r    <= 1'b1;
                        csr_raddr_r <= req_addr;
                        state_r     <= ST_READ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= CNT_LOAD;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        old_r <= csr_rdata;
                        if (op_writes(op_r)) begin
                            csr_we_r    <= 1'b1;
                            csr_waddr_r <= addr_r;
                            csr_wdata_r <= (op_r == CSR_OP_XCHG) ? merge_s : wdata_r;
                            state_r     <= ST_WRITE;
                        end else begin
                            resp_valid_r <= 1'b1;
                            state_r      <= ST_RESP;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (flush || resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // flush must suppress a write or response already registered for this
    // cycle, so those two strobes are qualified combinationally
    assign csr_we     = csr_we_r && !flush;
    assign resp_valid = resp_valid_r && !flush;

    assign req_ready  = (state_r == ST_IDLE) && !flush;
    assign busy       = (state_r != ST_IDLE);
    assign csr_re     = csr_re_r;
    assign csr_raddr  = csr_raddr_r;
    assign csr_waddr  = csr_waddr_r;
    assign csr_wdata  = csr_wdata_r;
    assign resp_data  = old_r;
    assign resp_rd    = rd_r;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csr_access_ctrl
//  Self-checking bench: instance "a" (RD_LAT=1) runs a vector table through a
//  scoreboard plus flush / back-pressure sequences; instance "b" (RD_LAT=3)
//  checks long read latency and a reset pulse in WAIT.
// ----------------------------------------------------------------------------
module tb_csr_access_ctrl;

    typedef struct {
        logic [1:0]  op;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        logic [4:0]  rd;
        logic [31:0] old;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;

    // ---------------- instance a, RD_LAT = 1 ----------------
    logic        rst, flush, req_valid, req_ready, csr_re, csr_we;
    logic        resp_valid, resp_ready, busy;
    logic [1:0]  req_op;
    logic [13:0] req_addr, csr_raddr, csr_waddr;
    logic [31:0] req_wdata, req_mask, csr_rdata, csr_wdata, resp_data;
    logic [4:0]  req_rd, resp_rd;

    csr_access_ctrl #(.CSR_AW(14), .DW(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask), .req_rd(req_rd),
        .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .busy(busy)
    );

    // CSR-file read model: data valid only in the cycle RD_LAT after csr_re
    logic        a_rv = 1'b0;
    logic [31:0] a_old = 32'h0;
    always @(posedge clk) a_rv <= csr_re;
    assign csr_rdata = a_rv ? a_old : 32'hBAD0_BAD0;

    // ---------------- instance b, RD_LAT = 3 ----------------
    logic        b_rst, b_flush, b_req_valid, b_req_ready, b_csr_re, b_csr_we;
    logic        b_resp_valid, b_resp_ready, b_busy;
    logic [1:0]  b_req_op;
    logic [13:0] b_req_addr, b_csr_raddr, b_csr_waddr;
    logic [31:0] b_req_wdata, b_req_mask, b_csr_rdata, b_csr_wdata, b_resp_data;
    logic [4:0]  b_req_rd, b_resp_rd;

    csr_access_ctrl #(.CSR_AW(14), .DW(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_mask(b_req_mask), .req_rd(b_req_rd),
        .csr_re(b_csr_re), .csr_raddr(b_csr_raddr), .csr_rdata(b_csr_rdata),
        .csr_we(b_csr_we), .csr_waddr(b_csr_waddr), .csr_wdata(b_csr_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .resp_rd(b_resp_rd), .busy(b_busy)
    );

    logic [2:0]  b_rv = 3'b000;
    logic [31:0] b_old = 32'h0;
    always @(posedge clk) b_rv <= {b_rv[1:0], b_csr_re};
    assign b_csr_rdata = b_rv[2] ? b_old : 32'hBAD0_BAD0;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- scoreboard monitor for instance a ----------------
    exp_t sb[$];
    bit   mon_en = 1'b0;
    int   hs_cyc = 0;

    initial begin
        int          wr_cnt;
        logic        rv_prev;
        logic [31:0] data_prev;
        logic [4:0]  rd_prev;
        wr_cnt  = 0;
        rv_prev = 1'b0;
        data_prev = 32'h0;
        rd_prev = 5'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (csr_re && csr_we) note_fail("re_we_same_cycle");
                if (csr_re) begin
                    if (sb.size() == 0) note_fail("unexpected_csr_re");
                    else begin
                        chk("re_cycle", 32'(cyc), 32'(sb[0].acc + 1));
                        chk("raddr", 32'(csr_raddr), 32'(sb[0].v.addr));
                    end
                end
                if (csr_we) begin
                    if (sb.size() == 0) note_fail("unexpected_csr_we");
                    else begin
                        wr_cnt++;
                        chk("we_cycle", 32'(cyc), 32'(sb[0].acc + 3));
                        chk("waddr", 32'(csr_waddr), 32'(sb[0].v.addr));
                        chk("wdata", csr_wdata, sb[0].v.exp_wdata);
                    end
                end
                if (resp_valid) begin
                    if (sb.size() == 0) note_fail("unexpected_resp");
                    else begin
                        if (!rv_prev)
                            chk("resp_latency", 32'(cyc), 32'(sb[0].acc + 3 + int'(sb[0].v.exp_we)));
                        else begin
                            chk("resp_data_stable", resp_data, data_prev);
                            chk("resp_rd_stable", 32'(resp_rd), 32'(rd_prev));
                        end
                        chk("resp_data", resp_data, sb[0].v.old);
                        chk("resp_rd", 32'(resp_rd), 32'(sb[0].v.rd));
                        if (resp_ready) begin
                            chk("write_count", 32'(wr_cnt), 32'(sb[0].v.exp_we));
                            void'(sb.pop_front());
                            wr_cnt = 0;
                            hs_cyc = cyc;
                        end
                    end
                end
                rv_prev   = resp_valid && !resp_ready;
                data_prev = resp_data;
                rd_prev   = resp_rd;
            end else begin
                rv_prev = 1'b0;
                wr_cnt  = 0;
            end
        end
    end

    // Drive one request on instance a and wait (bounded) for acceptance
    task automatic issue(input vec_t v, input bit push);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        a_old     = v.old;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_mask  = v.mask;
        req_rd    = v.rd;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 40);
        if (!req_ready) note_fail("accept_timeout");
        else if (push) begin
            e.v   = v;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || busy) && n < 60);
        if (sb.size() != 0 || busy) begin
            note_fail("idle_timeout");
            sb.delete();
        end
    endtask

    vec_t vecs[7];
    vec_t va, vb;

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //           op     addr      wdata         mask          rd     old           we    exp_wdata
        vecs[0] = '{2'b00, 14'h0005, 32'h0000_0000, 32'h0000_0000, 5'd3,  32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1] = '{2'b01, 14'h0006, 32'h1234_5678, 32'h0000_0000, 5'd7,  32'hA5A5_A5A5, 1'b1, 32'h1234_5678};
        vecs[2] = '{2'b10, 14'h0007, 32'h0F0F_0F0F, 32'h00FF_FF00, 5'd9,  32'hFFFF_0000, 1'b1, 32'hFF0F_0F00};
        vecs[3] = '{2'b10, 14'h0010, 32'hFFFF_FFFF, 32'h0000_0000, 5'd12, 32'h1357_9BDF, 1'b1, 32'h1357_9BDF};
        vecs[4] = '{2'b10, 14'h0011, 32'hCAFE_F00D, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b1, 32'hCAFE_F00D};
        vecs[5] = '{2'b11, 14'h3FFF, 32'h1111_1111, 32'hFFFF_FFFF, 5'd31, 32'h0BAD_CAFE, 1'b0, 32'h0000_0000};
        vecs[6] = '{2'b01, 14'h0000, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 14'h0;
        req_wdata = 32'h0; req_mask = 32'h0; req_rd = 5'd0; resp_ready = 1'b1;
        b_rst = 1'b1; b_flush = 1'b0; b_req_valid = 1'b0; b_req_op = 2'b00; b_req_addr = 14'h0;
        b_req_wdata = 32'h0; b_req_mask = 32'h0; b_req_rd = 5'd0; b_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_csr_re", 32'(csr_re), 32'd0);
        chk("rst_csr_we", 32'(csr_we), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_raddr", 32'(csr_raddr), 32'd0);
        chk("rst_waddr", 32'(csr_waddr), 32'd0);
        chk("rst_wdata", csr_wdata, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Table-driven ops through the scoreboard
        mon_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i], 1'b1);
            wait_idle();
        end

        // Back-pressure: resp_ready low for 5 cycles while a second request waits
        va = '{2'b01, 14'h0020, 32'h7777_0000, 32'h0, 5'd5, 32'h0123_4567, 1'b1, 32'h7777_0000};
        vb = '{2'b00, 14'h0021, 32'h0,         32'h0, 5'd6, 32'h89AB_CDEF, 1'b0, 32'h0};
        @(posedge clk); #1;
        resp_ready = 1'b0;
        issue(va, 1'b1);
        req_op = vb.op; req_addr = vb.addr; req_wdata = vb.wdata;
        req_mask = vb.mask; req_rd = vb.rd; req_valid = 1'b1;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) note_fail("stall_resp_timeout");
        a_old = vb.old;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        chk("b2b_accept_cycle", 32'(cyc), 32'(hs_cyc + 1));
        if (req_ready) begin
            sb.push_back('{vb, cyc});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();

        // Flush in the WRITE cycle: no write, no response, idle next cycle
        mon_en = 1'b0;
        issue(vecs[1], 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_we", 32'(csr_we), 32'd0);
        chk("flush_busy_write", 32'(busy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("flush_no_resp", 32'(resp_valid), 32'd0);
            chk("flush_no_we", 32'(csr_we), 32'd0);
            @(negedge clk);
        end

        // Flush in IDLE with a request pending: not accepted
        @(posedge clk); #1;
        flush = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk("idle_flush_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", 32'(busy), 32'd0);
        chk("idle_flush_no_re", 32'(csr_re), 32'd0);

        // RD_LAT=3: capture happens in the third WAIT cycle
        @(posedge clk); #1;
        b_old = 32'h600D_F00D;
        b_req_op = 2'b00; b_req_addr = 14'h0042; b_req_rd = 5'd17; b_req_valid = 1'b1;
        @(negedge clk);
        chk("b_req_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("b_csr_re", 32'(b_csr_re), 32'd1);
        chk("b_raddr", 32'(b_csr_raddr), 32'h0042);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_no_early_resp", 32'(b_resp_valid), 32'd0);
        end
        @(negedge clk);
        chk("b_resp_valid", 32'(b_resp_valid), 32'd1);
        chk("b_resp_data", b_resp_data, 32'h600D_F00D);
        chk("b_resp_rd", 32'(b_resp_rd), 32'd17);
        @(negedge clk);
        chk("b_idle", 32'(b_busy), 32'd0);

        // RD_LAT=3: reset pulse in the middle of WAIT on a write op
        @(posedge clk); #1;
        b_old = 32'h5555_AAAA;
        b_req_op = 2'b01; b_req_addr = 14'h0043; b_req_wdata = 32'h1357_2468;
        b_req_rd = 5'd4; b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rst = 1'b1;
        @(negedge clk);
        chk("b_busy_before_rst", 32'(b_busy), 32'd1);
        @(posedge clk); #1;
        b_rst = 1'b0;
        @(negedge clk);
        chk("b_rst_busy", 32'(b_busy), 32'd0);
        chk("b_rst_ready", 32'(b_req_ready), 32'd1);
        chk("b_rst_raddr", 32'(b_csr_raddr), 32'd0);
        chk("b_rst_resp_data", b_resp_data, 32'd0);
        chk("b_rst_resp_rd", 32'(b_resp_rd), 32'd0);
        chk("b_rst_wdata", b_csr_wdata, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("b_rst_no_we", 32'(b_csr_we), 32'd0);
            chk("b_rst_no_resp", 32'(b_resp_valid), 32'd0);
            chk("b_rst_no_re", 32'(b_csr_re), 32'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
